// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder                                                  |
// | Purpose  : Multi-cycle data-memory slave with fixed access latency and a   |
// |            registered req/ack handshake. Optional macro: DMEM_BYTE_EN_EN   |
// |            adds be_i byte-lane write enables.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]  be_i,
`endif
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int         c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [7:0] c_cnt_load = 8'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $fatal(1, "dmem_responder: LATENCY must be in 1..255");
        end
        if (DEPTH_WORDS < 1 || DEPTH_WORDS > (1 << 30)) begin : g_bad_depth
            $fatal(1, "dmem_responder: DEPTH_WORDS must be in 1..2**30");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;

    logic               r_wr;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [3:0]         r_be;

    logic [31:0]        r_mem [DEPTH_WORDS];

    logic [3:0]         w_be_in;
    logic               w_latch;
    logic               w_access;
    logic               w_acc_wr;
    logic [31:0]        w_acc_addr;
    logic [31:0]        w_acc_data;
    logic [3:0]         w_acc_be;
    logic               w_acc_err;
    logic [c_idx_w-1:0] w_acc_idx;
    logic [31:0]        w_rd_word;
    logic               w_mem_we;

    logic               w_ack_nxt;
    logic               w_err_nxt;
    logic               w_busy_nxt;
    logic [31:0]        w_data_nxt;

`ifdef DMEM_BYTE_EN_EN
    assign w_be_in = be_i;
`else
    assign w_be_in = 4'hF;
`endif

    // With LATENCY=1 the access happens on the accepting edge, so it must
    // use the live request fields; otherwise it uses the latched copy.
    assign w_acc_wr   = (r_state == S_IDLE) ? wr_i    : r_wr;
    assign w_acc_addr = (r_state == S_IDLE) ? addr_i  : r_addr;
    assign w_acc_data = (r_state == S_IDLE) ? data_i  : r_data;
    assign w_acc_be   = (r_state == S_IDLE) ? w_be_in : r_be;

    assign w_acc_err  = (w_acc_addr[1:0] != 2'b00) ||
                        ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_acc_idx  = w_acc_addr[c_idx_w+1:2];
    assign w_rd_word  = r_mem[w_acc_idx];
    assign w_mem_we   = w_access && !w_acc_err && w_acc_wr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = busy_o;
        w_data_nxt  = data_o;

        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_latch    = 1'b1;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = c_cnt_load;
                    if (LATENCY == 1) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_access) begin
            w_ack_nxt = 1'b1;
            w_err_nxt = w_acc_err;
            if (w_acc_err) begin
                w_data_nxt = 32'h0;
            end else if (!w_acc_wr) begin
                w_data_nxt = w_rd_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            data_o  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            ack_o   <= w_ack_nxt;
            err_o   <= w_err_nxt;
            busy_o  <= w_busy_nxt;
            data_o  <= w_data_nxt;
        end
    end

    // Request fields are pure datapath; the FSM decides when they matter.
    always_ff @(posedge clk_i) begin
        if (w_latch) begin
            r_wr   <= wr_i;
            r_addr <= addr_i;
            r_data <= data_i;
            r_be   <= w_be_in;
        end
    end

    // Array is never cleared; reset only suppresses a write in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_acc_be[k]) begin
                    r_mem[w_acc_idx][8*k +: 8] <= w_acc_data[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                               |
// | Purpose  : Self-checking bench for dmem_responder (LATENCY=10 and 1).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int LAT0  = 10;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr_s;
    logic [31:0] addr_s, data_s;
    logic [3:0]  be;
    logic [31:0] data_o;
    logic        ack, err, busy;

    logic        req1, wr1;
    logic [31:0] addr1, data1;
    logic [3:0]  be1;
    logic [31:0] data_o1;
    logic        ack1, err1, busy1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_data;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr_s),
        .addr_i(addr_s), .data_i(data_s),
`ifdef DMEM_BYTE_EN_EN
        .be_i(be),
`endif
        .data_o(data_o), .ack_o(ack), .err_o(err), .busy_o(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .wr_i(wr1),
        .addr_i(addr1), .data_i(data1),
`ifdef DMEM_BYTE_EN_EN
        .be_i(be1),
`endif
        .data_o(data_o1), .ack_o(ack1), .err_o(err1), .busy_o(busy1)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] bev);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (bev[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    // One full transaction on the LATENCY=10 instance with timing checks.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] bev, input logic exp_err,
                          input logic [31:0] exp_rd, input string tag);
        int          k;
        logic        got;
        logic [31:0] exp_d;
        @(negedge clk);
        req = 1'b1; wr_s = w; addr_s = a; data_s = d; be = bev;
        @(posedge clk); #1;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_hold"}, data_o, last_data);
        k = 1; got = 1'b0;
        while (!got && k <= 300) begin
            if (ack) got = 1'b1;
            else begin
                @(posedge clk); #1; k++;
            end
        end
        chk({tag, "_ack_seen"}, got, 1);
        chk({tag, "_latency"}, k, LAT0);
        chk({tag, "_err"}, err, exp_err);
        exp_d = exp_err ? 32'h0 : (w ? last_data : exp_rd);
        chk({tag, "_data"}, data_o, exp_d);
        last_data = exp_d;
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, "_ack_off"}, ack, 0);
        chk({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic        got;
        logic [31:0] a, d, exp_rd;
        logic        w, e;
        logic [3:0]  bev;
        int          widx, r;

        rst = 1'b1; req = 1'b0; wr_s = 1'b0; addr_s = '0; data_s = '0; be = 4'hF;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; data1 = '0; be1 = 4'hF;
        last_data = 32'h0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        chk("rst_ack", ack, 0);   chk("rst_err", err, 0);
        chk("rst_busy", busy, 0); chk("rst_data", data_o, 0);
        chk("rst_ack1", ack1, 0); chk("rst_busy1", busy1, 0);
        chk("rst_data1", data_o1, 0);

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_4000, 32'h1234_5678, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1122_3344};
        vecs[10] = '{1'b1, 32'h0000_0012, 32'h0BAD_F00D, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, 4'hF,
                   vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));
            if (vecs[i].wr && !vecs[i].exp_err) model[int'(vecs[i].addr >> 2)] = vecs[i].data;
        end

        // Held request with fields toggling during WAIT must not disturb the write.
        @(negedge clk);
        req = 1'b1; wr_s = 1'b1; addr_s = 32'h20; data_s = 32'h55; be = 4'hF;
        @(posedge clk);
        k = 1; got = 1'b0;
        #1;
        while (!got && k <= 300) begin
            @(negedge clk);
            addr_s = $urandom; data_s = $urandom; wr_s = 1'($urandom);
            @(posedge clk); #1; k++;
            if (ack) got = 1'b1;
        end
        chk("toggle_ack_seen", got, 1);
        chk("toggle_latency", k, LAT0);
        chk("toggle_err", err, 0);
        chk("toggle_data", data_o, last_data);
        @(posedge clk); #1; req = 1'b0;
        model[8] = 32'h55;

        // Reset three cycles into a second write aborts it.
        @(negedge clk);
        req = 1'b1; wr_s = 1'b1; addr_s = 32'h20; data_s = 32'h77;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1; chk("abort_busy_pre", busy, 1);
        @(negedge clk); rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack", ack, 0); chk("abort_busy", busy, 0);
        chk("abort_data", data_o, 0); chk("abort_err", err, 0);
        rst = 1'b0;
        last_data = 32'h0;
        do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h55, "abort_rd");

        // Randomized traffic against an associative-array memory model.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            widx = $urandom_range(0, 11);
            if (widx >= 8) widx = widx + 1012;
            a = 32'(widx) << 2;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = 32'($urandom_range(DEPTH, 1 << 20)) << 2;
            w = 1'($urandom);
            d = $urandom;
            e = addr_err(a);
            if (!e && !model.exists(widx)) w = 1'b1;
            bev = 4'hF;
`ifdef DMEM_BYTE_EN_EN
            if (!e && model.exists(widx)) bev = 4'($urandom_range(0, 15));
`endif
            exp_rd = (!e && !w) ? model[widx] : 32'h0;
            do_req(w, a, d, bev, e, exp_rd, $sformatf("rnd%0d", i));
            if (!e && w) model[widx] = model.exists(widx) ? merge(model[widx], d, bev) : d;
        end

`ifdef DMEM_BYTE_EN_EN
        do_req(1'b1, 32'h0, 32'h1122_3344, 4'hF,    1'b0, 32'h0, "be_init");
        do_req(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, "be_0101");
        do_req(1'b0, 32'h0, 32'h0,         4'hF,    1'b0, 32'h11BB_33DD, "be_rd1");
        do_req(1'b1, 32'h0, 32'h9999_9999, 4'b0000, 1'b0, 32'h0, "be_0000");
        do_req(1'b0, 32'h0, 32'h0,         4'b0000, 1'b0, 32'h11BB_33DD, "be_rd2");
`endif

        // LATENCY=1 instance: req held high, one ack every two cycles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req1 = 1'b1; wr1 = (i < 4); addr1 = 32'h40 + 32'(4 * (i % 4));
            data1 = 32'hA5A5_0000 + 32'(i % 4);
            @(posedge clk); #1;
            chk($sformatf("l1_ack%0d", i), ack1, 1);
            chk($sformatf("l1_err%0d", i), err1, 0);
            chk($sformatf("l1_busy%0d", i), busy1, 1);
            if (i >= 4) chk($sformatf("l1_data%0d", i), data_o1, 32'hA5A5_0000 + 32'(i % 4));
            @(posedge clk); #1;
            chk($sformatf("l1_gap%0d", i), ack1, 0);
            chk($sformatf("l1_idle%0d", i), busy1, 0);
            if (i >= 4) chk($sformatf("l1_hold%0d", i), data_o1, 32'hA5A5_0000 + 32'(i % 4));
        end
        @(negedge clk); req1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder. It is the slave end of the CPU/cache data-memory request interface. It accepts one word request at a time on a registered req/ack handshake, models a fixed access latency, then completes the read or write against an internal word array. It replaces the single-cycle data memory behind the MEM stage when the pipeline is built with a stalling memory path.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = addr_i[31:2]
LATENCY, 10, cycles from request acceptance to ack; legal range 1..255

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
req_i  input  1  request valid; initiator holds it high until it sees ack_o
wr_i  input  1  1 = write, 0 = read; sampled with req_i
addr_i  input  32  byte address; sampled with req_i
data_i  input  32  write data; sampled with req_i
data_o  output  32  read data; valid in the ack_o cycle, held until the next ack
ack_o  output  1  one-cycle completion pulse (registered)
err_o  output  1  qualifies ack_o: request was misaligned or out of range (registered)
busy_o  output  1  high whenever state != IDLE (registered); used as the pipeline stall

Behaviour:
- Reset: state=IDLE, counter=0, ack_o=0, err_o=0, busy_o=0, data_o=0.
- Array contents are not cleared by reset.
- Reset mid-operation discards the pending request. A pending write is not performed.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If req_i=1 at the edge: latch wr_i, addr_i, data_i; load counter=LATENCY-1; busy_o<=1.
  - Next state is WAIT, or ACK directly when LATENCY=1.
  - If req_i=0, stay in IDLE.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==1 (or on entry when LATENCY=1), perform the access and go to ACK.
- Access:
  - err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH_WORDS).
  - err=0, write: mem[idx]<=data; data_o is unchanged.
  - err=0, read: data_o<=mem[idx].
  - err=1: no array write; data_o<=0.
  - ack_o<=1 and err_o<=err are set on the same edge.
- ACK:
  - ack_o=1 for exactly one cycle.
  - Next edge: state=IDLE, ack_o<=0, err_o<=0, busy_o<=0.
- Latency: a request accepted at edge E0 gives ack_o high during the cycle after edge E0+LATENCY-1. The ack cycle is LATENCY cycles after acceptance.
- Handshake:
  - The initiator deasserts req_i on the edge ending the ack cycle.
  - req_i, wr_i, addr_i and data_i are ignored in WAIT and ACK. Changing them mid-request has no effect.
  - req_i still high in IDLE after ACK is a new request.
- There is only one outstanding request, with no queueing.
- Read-after-write to the same address on back-to-back requests returns the new data.
- Counter width is 8 bits and never wraps, because of the LATENCY range check.
- Illegal LATENCY (0 or >255) is a fatal elaboration error.

Optional Feature:
DMEM_BYTE_EN_EN:
- Defined: adds port be_i input 4, latched with req_i.
  - On a non-error write, only bytes with be_i[k]=1 update mem[idx][8k+7:8k].
  - Reads ignore be_i.
  - be_i=0000 write completes with ack and modifies nothing.
- Undefined: no be_i port; every write updates the full 32-bit word.

Test Plan:
- Reset, then write addr 0x10 data 0xDEADBEEF (LATENCY=10) -> busy_o=1 the cycle after acceptance; ack_o high exactly 10 cycles after acceptance for 1 cycle; err_o=0; busy_o=0 the following cycle.
- Read addr 0x10 after the previous write -> ack_o after 10 cycles with data_o=0xDEADBEEF; data_o holds 0xDEADBEEF until the next ack.
- Read addr 0x13 (misaligned) and addr 0x1000 (DEPTH_WORDS=1024, index 1024) -> each acks with err_o=1, data_o=0; mem[4] still reads 0xDEADBEEF afterwards.
- Write 0x55 to 0x20; hold req_i and toggle addr_i/data_i during WAIT; raise rst_i 3 cycles into a second write of 0x77 to 0x20 -> the first write lands 0x55 unaffected by toggles; reset gives ack_o=0, busy_o=0, data_o=0 next cycle; later read of 0x20 returns 0x55.
- LATENCY=1 build: back-to-back reads with req_i re-asserted in the IDLE cycle after ack -> ack every 2 cycles, data correct each time.
- DMEM_BYTE_EN_EN: mem[0]=0x11223344, write 0xAABBCCDD with be_i=0101 -> read returns 0x11BB33DD; write with be_i=0000 -> value unchanged, ack_o still pulses.
